// File: rtl/seg_disp_pkg.sv
// Shared constants and state type for the 7-segment frame selector.
package seg_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  typedef enum logic {
    SHOW = 1'b0,
    HOLD = 1'b1
  } disp_state_t;

endpackage

// File: rtl/blink_gen.sv
// Free-running blink phase generator: phase toggles every BLINK_DIV cycles.
module blink_gen #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic phase
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_display_mux.sv
// Registered frame selector with blanking on channel switch.
// Digit blinking is built only when SEG_DISP_BLINK_EN is defined.
//
// state | meaning
// SHOW  | committed channel's frame is on the display (blink masking active)
// HOLD  | blank interval after a channel switch, cnt counts down to exit
module seg_display_mux
  import seg_disp_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DIGITS    = 8,
  parameter int SEG_W     = 7,
  parameter int BLANK_CYC = 2,
  parameter int BLINK_DIV = 25_000_000,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH*DIGITS*SEG_W-1:0] ch_data,
  input  logic [CH_W-1:0]                mode,
  input  logic                           override_en,
  input  logic [CH_W-1:0]                override_ch,
  input  logic [DIGITS-1:0]              blink_mask,
  output logic [DIGITS*SEG_W-1:0]        seg,
  output logic [CH_W-1:0]                sel_ch,
  output logic                           switching
);

  localparam int FRAME_W = DIGITS * SEG_W;
  localparam int CNT_W   = (BLANK_CYC > 2) ? $clog2(BLANK_CYC) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD    = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [FRAME_W-1:0] FRAME_BLANK = '1;

  disp_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CH_W-1:0]    tgt, sel_d;
  logic [FRAME_W-1:0] shown, seg_d;
  logic               sw_d;

  assign tgt = override_en ? override_ch : mode;

`ifdef SEG_DISP_BLINK_EN
  logic phase;

  blink_gen #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .phase(phase)
  );
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SHOW;
      cnt_q     <= '0;
      sel_ch    <= '0;
      switching <= 1'b0;
      seg       <= FRAME_BLANK;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_ch    <= sel_d;
      switching <= sw_d;
      seg       <= seg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_ch;
    case (state_q)
      SHOW: begin
        if (tgt != sel_ch) begin
          sel_d = tgt;
          if (BLANK_CYC > 0) begin
            state_d = HOLD;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      HOLD: begin
        // A fresh target restarts the whole blank interval.
        if (tgt != sel_ch) begin
          sel_d = tgt;
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = SHOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = SHOW;
    endcase
  end

  // Whenever a frame is shown the target equals the committed channel, so mux on tgt.
  always_comb begin
    shown = FRAME_BLANK;
    for (int k = 0; k < NUM_CH; k++) begin
      if (tgt == CH_W'(k)) shown = ch_data[k*FRAME_W +: FRAME_W];
    end
`ifdef SEG_DISP_BLINK_EN
    for (int d = 0; d < DIGITS; d++) begin
      if (phase && blink_mask[d]) shown[d*SEG_W +: SEG_W] = '1;
    end
`endif
    sw_d  = (state_d == HOLD);
    seg_d = sw_d ? FRAME_BLANK : shown;
  end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Registered, parametrised 7-segment frame selector for the calendar display path. It picks one of `NUM_CH` full-display frames (clock, date, alarm, d-day, …) using the user `mode` or a priority override channel, such as d-day selection. Each channel switch inserts a blank-frame interval to suppress ghosting. While a field is being edited, selected digits blink. It sits between the per-function display encoders and the segment driver pins.

## Interface
- `NUM_CH`, 4, number of input frames (≥2)
- `DIGITS`, 8, digits per frame
- `SEG_W`, 7, segment bits per digit, active-low
- `BLANK_CYC`, 2, blank cycles inserted on a channel switch (0 = none)
- `BLINK_DIV`, 25_000_000, clock cycles per blink half-period (≥2)
- `CH_W`, `$clog2(NUM_CH)`, derived; not overridden
---
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `ch_data`  in  NUM_CH*DIGITS*SEG_W  frames packed as concatenated per-channel slices; channel k occupies `[k*DIGITS*SEG_W +: DIGITS*SEG_W]`
- `mode`  in  CH_W  user-selected channel
- `override_en`  in  1  force `override_ch` instead of `mode`
- `override_ch`  in  CH_W  override channel, e.g. d-day select
- `blink_mask`  in  DIGITS  1 = digit blinks; bit i maps to digit i
- `seg`  out  DIGITS*SEG_W  registered display frame
- `sel_ch`  out  CH_W  channel currently committed to display
- `switching`  out  1  high while a blank interval is in progress

## Operation
- Target channel: `tgt = override_en ? override_ch : mode`.
- Out of range (`tgt ≥ NUM_CH`): frame is all-BLANK (all ones). `sel_ch` still takes `tgt`.
- The FSM has two states, SHOW and HOLD.
  - SHOW → HOLD when `tgt != sel_ch` and `BLANK_CYC > 0`. On entry, load `cnt = BLANK_CYC-1`, latch `sel_ch <= tgt` and assert `switching`. `seg` is BLANK.
  - If `BLANK_CYC == 0`, `sel_ch <= tgt` directly and the FSM stays in SHOW.
  - HOLD: `cnt` decrements each cycle. When `cnt == 0` and `tgt == sel_ch`, go to SHOW and deassert `switching`.
  - HOLD, `tgt` changes again: re-latch `sel_ch`, reload `cnt = BLANK_CYC-1` and stay in HOLD, so the count restarts.
- SHOW output: `seg <= frame(sel_ch)` with blink masking applied.
- Blink: a free-running counter runs 0..BLINK_DIV-1. At wrap, `phase` toggles. When `phase == 1`, every digit whose `blink_mask` bit is set is forced to BLANK. When `phase == 0`, all digits are visible.
- Blink masking applies only in SHOW. HOLD is blank regardless.
- Frame data is sampled every cycle, so live content updates with 1-cycle latency and no blanking.

## Timing
- Reset values: `seg` = all ones, `sel_ch` = 0, `switching` = 0, state SHOW, `cnt` = 0, blink counter = 0, `phase` = 0.
- Reset is honoured mid-HOLD or mid-blink. After release, a non-zero `tgt` triggers a normal switch sequence.
- Channel change seen at edge N:
  - `switching` goes high at N+1.
  - `seg` is BLANK for N+1..N+BLANK_CYC.
  - The new frame appears at N+BLANK_CYC+1.
  - With `BLANK_CYC == 0`, the new frame appears at N+1.
- A data-only change within the same channel appears on `seg` one cycle later.
- Blink phase toggles every BLINK_DIV cycles. The first toggle after reset lands at cycle BLINK_DIV.
- `override_en` rising or falling counts as a `tgt` change only if the resulting channel differs from `sel_ch`.

## Configuration
- `SEG_DISP_BLINK_EN` defined: the blink counter, `phase` and masking are built as described.
- Undefined: `blink_mask` is ignored, no counter logic is synthesised, and SHOW always outputs the full frame.

## Structure
- Package `seg_disp_pkg` holds:
  - `SEG_BLANK` (7'b111_1111), the per-digit blank constant
  - the `disp_state_t` enum {SHOW, HOLD}
- Sub-module `blink_gen` (params `BLINK_DIV`; ports `clk`, `rst_n`, `phase`) is instantiated only under `SEG_DISP_BLINK_EN`.

## Test plan
- Reset, `mode=0`, frame0 = 56'h0123456789ABCD: `seg` is all ones during reset and equals frame0 one cycle after release.
- `BLANK_CYC=2`, `mode` 0→2 at edge N: `switching` is high for N+1..N+2, `seg` is BLANK for 2 cycles, frame2 appears at N+3, `sel_ch=2`.
- In HOLD, `mode` 2→1 one cycle into the blank: count restarts, so BLANK lasts 2 more cycles and frame1 then appears.
- `override_en=1`, `override_ch=3`, `mode=2`: frame3 is shown. `override_en`→0: switch back to frame2 with blanking.
- `NUM_CH=3`, `mode=3`: `seg` is all ones persistently and `sel_ch=3`.
- `BLINK_DIV=4`, `blink_mask=8'b0000_0011`: digits 0–1 alternate frame/BLANK every 4 cycles and digits 2–7 stay steady. Without `SEG_DISP_BLINK_EN`, no digit blanks.
